pipeline_stall_controller: RTL and testbench

- Central sequencer for the 16-bit CPU's four pipeline registers: IF/ID, ID/EX, EX/MEM and MEM/WB.
- Generates per-stage hold (enable) and bubble (flush) controls for:
  - load-use hazards;
  - taken-branch redirects;
  - multi-cycle data-memory accesses;
  - program halt.
- Sits beside the pipeline registers and drives their enable/flush inputs. The EX/MEM register gains an enable from this block.

---
 rtl/pipe_ctrl_pkg.sv | 43 ++++
 rtl/pipeline_stall_controller_load_use_detect.sv | 17 +
 rtl/pipeline_stall_controller.sv | 147 ++++++++++++++
 tb/tb_pipeline_stall_controller.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and control-word constants for the pipeline stall controller.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    HALT     = 2'd2
  } pipe_state_t;

  typedef struct packed {
    logic pc_en;
    logic ifid_en;
    logic ifid_flush;
    logic idex_en;
    logic idex_flush;
    logic exmem_en;
    logic memwb_flush;
    logic mem_busy;
    logic halted;
  } pipe_ctrl_t;

  localparam pipe_ctrl_t CTRL_RUN = '{
    pc_en: 1'b1, ifid_en: 1'b1, ifid_flush: 1'b0, idex_en: 1'b1, idex_flush: 1'b0,
    exmem_en: 1'b1, memwb_flush: 1'b0, mem_busy: 1'b0, halted: 1'b0};

  localparam pipe_ctrl_t CTRL_FREEZE = '{
    pc_en: 1'b0, ifid_en: 1'b0, ifid_flush: 1'b0, idex_en: 1'b0, idex_flush: 1'b0,
    exmem_en: 1'b0, memwb_flush: 1'b1, mem_busy: 1'b1, halted: 1'b0};

  localparam pipe_ctrl_t CTRL_RESET = '{
    pc_en: 1'b0, ifid_en: 1'b0, ifid_flush: 1'b1, idex_en: 1'b0, idex_flush: 1'b1,
    exmem_en: 1'b0, memwb_flush: 1'b1, mem_busy: 1'b0, halted: 1'b0};

  // Halt freezes everything like a memory stall but is not a memory access.
  localparam pipe_ctrl_t CTRL_HALT_ENTRY = '{
    pc_en: 1'b0, ifid_en: 1'b0, ifid_flush: 1'b0, idex_en: 1'b0, idex_flush: 1'b0,
    exmem_en: 1'b0, memwb_flush: 1'b1, mem_busy: 1'b0, halted: 1'b0};

  localparam pipe_ctrl_t CTRL_HALTED = '{
    pc_en: 1'b0, ifid_en: 1'b0, ifid_flush: 1'b0, idex_en: 1'b0, idex_flush: 1'b0,
    exmem_en: 1'b0, memwb_flush: 1'b1, mem_busy: 1'b0, halted: 1'b1};

endpackage

// File: rtl/pipeline_stall_controller_load_use_detect.sv
// Load-use hazard comparator: the load in EX writes a register the ID instruction reads.
module load_use_detect #(
  parameter int unsigned REG_AW = 4
) (
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_uses_rs2,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_mem_read,
  output logic              hazard
);

  always_comb begin
    hazard = ex_mem_read && ((id_rs1 == ex_rd) || (id_uses_rs2 && (id_rs2 == ex_rd)));
  end

endmodule

// File: rtl/pipeline_stall_controller.sv
// Pipeline hold/bubble sequencer for load-use, branch, memory-wait and halt.
// Optional PIPE_STALL_PERF_EN adds saturating stall/flush event counters.
module pipeline_stall_controller
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned REG_AW  = 4,
  parameter int unsigned MEM_LAT = 2,
  parameter int unsigned CNT_W   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_uses_rs2,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_mem_read,
  input  logic              branch_taken,
  input  logic              mem_req,
  input  logic              halt_req,
  output logic              pc_en,
  output logic              ifid_en,
  output logic              ifid_flush,
  output logic              idex_en,
  output logic              idex_flush,
  output logic              exmem_en,
  output logic              memwb_flush,
  output logic              mem_busy,
  output logic              halted
`ifdef PIPE_STALL_PERF_EN
  ,
  output logic [15:0]       stall_cycles,
  output logic [15:0]       flush_events
`endif
);

  localparam logic [CNT_W-1:0] CNT_INIT = (MEM_LAT > 1) ? CNT_W'(MEM_LAT - 2) : '0;

  pipe_state_t      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  pipe_ctrl_t       ctrl;
  logic             hazard;
  logic             apply_hazards;
  logic             branch_flush;

  load_use_detect #(.REG_AW(REG_AW)) u_load_use (
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_uses_rs2 (id_uses_rs2),
    .ex_rd       (ex_rd),
    .ex_mem_read (ex_mem_read),
    .hazard      (hazard)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    ctrl          = CTRL_RUN;
    state_d       = state_q;
    cnt_d         = cnt_q;
    apply_hazards = 1'b0;
    branch_flush  = 1'b0;
    if (rst) begin
      ctrl    = CTRL_RESET;
      state_d = RUN;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        RUN: begin
          if (halt_req) begin
            ctrl    = CTRL_HALT_ENTRY;
            state_d = HALT;
          end else if ((MEM_LAT > 1) && mem_req) begin
            ctrl    = CTRL_FREEZE;
            state_d = MEM_WAIT;
            cnt_d   = CNT_INIT;
          end else begin
            apply_hazards = 1'b1;
          end
        end
        MEM_WAIT: begin
          if (cnt_q != '0) begin
            ctrl  = CTRL_FREEZE;
            cnt_d = cnt_q - CNT_W'(1);
          end else begin
            // Release cycle: the held mem_req belongs to the finishing access.
            state_d       = RUN;
            apply_hazards = 1'b1;
          end
        end
        HALT: ctrl = CTRL_HALTED;
        default: begin
          ctrl    = CTRL_RESET;
          state_d = RUN;
          cnt_d   = '0;
        end
      endcase

      if (apply_hazards) begin
        if (branch_taken) begin
          ctrl.ifid_flush = 1'b1;
          ctrl.idex_flush = 1'b1;
          branch_flush    = 1'b1;
        end else if (hazard) begin
          ctrl.pc_en      = 1'b0;
          ctrl.ifid_en    = 1'b0;
          ctrl.idex_flush = 1'b1;
        end
      end
    end
  end

  always_comb begin
    pc_en       = ctrl.pc_en;
    ifid_en     = ctrl.ifid_en;
    ifid_flush  = ctrl.ifid_flush;
    idex_en     = ctrl.idex_en;
    idex_flush  = ctrl.idex_flush;
    exmem_en    = ctrl.exmem_en;
    memwb_flush = ctrl.memwb_flush;
    mem_busy    = ctrl.mem_busy;
    halted      = ctrl.halted;
  end

`ifdef PIPE_STALL_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles <= '0;
      flush_events <= '0;
    end else begin
      if (!ctrl.pc_en && (stall_cycles != '1)) stall_cycles <= stall_cycles + 16'd1;
      if (branch_flush && (flush_events != '1)) flush_events <= flush_events + 16'd1;
    end
  end
`else
  logic unused_branch_flush;
  always_comb unused_branch_flush = branch_flush;
`endif

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Directed checks of pipeline_stall_controller at MEM_LAT = 1, 2, 3 and 4.
module tb_pipeline_stall_controller;
  import pipe_ctrl_pkg::*;

  // {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_flush, mem_busy, halted}
  localparam logic [8:0] E_NORM  = 9'b1_1_0_1_0_1_0_0_0;
  localparam logic [8:0] E_FRZ   = 9'b0_0_0_0_0_0_1_1_0;
  localparam logic [8:0] E_RST   = 9'b0_0_1_0_1_0_1_0_0;
  localparam logic [8:0] E_HLTIN = 9'b0_0_0_0_0_0_1_0_0;
  localparam logic [8:0] E_HALT  = 9'b0_0_0_0_0_0_1_0_1;
  localparam logic [8:0] E_BR    = 9'b1_1_1_1_1_1_0_0_0;
  localparam logic [8:0] E_LU    = 9'b0_0_0_1_1_1_0_0_0;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] id_rs1, id_rs2, ex_rd;
  logic       id_uses_rs2, ex_mem_read, branch_taken, mem_req, halt_req;
  logic [8:0] o1, o2, o3, o4;
`ifdef PIPE_STALL_PERF_EN
  logic [15:0] sc1, sc2, sc3, sc4, fe1, fe2, fe3, fe4;
`endif

  int unsigned checks = 0;
  int unsigned errors = 0;

  always #5 clk = ~clk;

  pipeline_stall_controller #(.REG_AW(4), .MEM_LAT(1), .CNT_W(4)) dut1 (
    .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs2(id_uses_rs2),
    .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .branch_taken(branch_taken),
    .mem_req(mem_req), .halt_req(halt_req),
    .pc_en(o1[8]), .ifid_en(o1[7]), .ifid_flush(o1[6]), .idex_en(o1[5]), .idex_flush(o1[4]),
    .exmem_en(o1[3]), .memwb_flush(o1[2]), .mem_busy(o1[1]), .halted(o1[0])
`ifdef PIPE_STALL_PERF_EN
    , .stall_cycles(sc1), .flush_events(fe1)
`endif
  );

  pipeline_stall_controller #(.REG_AW(4), .MEM_LAT(2), .CNT_W(4)) dut2 (
    .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs2(id_uses_rs2),
    .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .branch_taken(branch_taken),
    .mem_req(mem_req), .halt_req(halt_req),
    .pc_en(o2[8]), .ifid_en(o2[7]), .ifid_flush(o2[6]), .idex_en(o2[5]), .idex_flush(o2[4]),
    .exmem_en(o2[3]), .memwb_flush(o2[2]), .mem_busy(o2[1]), .halted(o2[0])
`ifdef PIPE_STALL_PERF_EN
    , .stall_cycles(sc2), .flush_events(fe2)
`endif
  );

  pipeline_stall_controller #(.REG_AW(4), .MEM_LAT(3), .CNT_W(4)) dut3 (
    .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs2(id_uses_rs2),
    .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .branch_taken(branch_taken),
    .mem_req(mem_req), .halt_req(halt_req),
    .pc_en(o3[8]), .ifid_en(o3[7]), .ifid_flush(o3[6]), .idex_en(o3[5]), .idex_flush(o3[4]),
    .exmem_en(o3[3]), .memwb_flush(o3[2]), .mem_busy(o3[1]), .halted(o3[0])
`ifdef PIPE_STALL_PERF_EN
    , .stall_cycles(sc3), .flush_events(fe3)
`endif
  );

  pipeline_stall_controller #(.REG_AW(4), .MEM_LAT(4), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs2(id_uses_rs2),
    .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .branch_taken(branch_taken),
    .mem_req(mem_req), .halt_req(halt_req),
    .pc_en(o4[8]), .ifid_en(o4[7]), .ifid_flush(o4[6]), .idex_en(o4[5]), .idex_flush(o4[4]),
    .exmem_en(o4[3]), .memwb_flush(o4[2]), .mem_busy(o4[1]), .halted(o4[0])
`ifdef PIPE_STALL_PERF_EN
    , .stall_cycles(sc4), .flush_events(fe4)
`endif
  );

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs are then changed and outputs sampled mid-cycle.
  task automatic go;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    rst = 1'b0; id_rs1 = 4'd0; id_rs2 = 4'd0; ex_rd = 4'd0; id_uses_rs2 = 1'b0;
    ex_mem_read = 1'b0; branch_taken = 1'b0; mem_req = 1'b0; halt_req = 1'b0;
  endtask

  task automatic do_reset;
    idle_inputs();
    rst = 1'b1;
    go();
    rst = 1'b0;
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    #1;
    check("reset_l1", {7'd0, o1}, {7'd0, E_RST});
    check("reset_l2", {7'd0, o2}, {7'd0, E_RST});
    check("reset_l3", {7'd0, o3}, {7'd0, E_RST});
    check("reset_l4", {7'd0, o4}, {7'd0, E_RST});
    go();
    rst = 1'b0;
    #1;
    check("run_normal", {7'd0, o3}, {7'd0, E_NORM});
    go();

    // Load-use on rs1, then rs2 ignored/used, then hazard gone
    ex_mem_read = 1'b1; ex_rd = 4'd3; id_rs1 = 4'd3; #1;
    check("lu_rs1", {7'd0, o3}, {7'd0, E_LU});
    go();
    id_rs1 = 4'd5; id_rs2 = 4'd3; id_uses_rs2 = 1'b0; #1;
    check("lu_rs2_unused", {7'd0, o3}, {7'd0, E_NORM});
    go();
    id_uses_rs2 = 1'b1; #1;
    check("lu_rs2_used", {7'd0, o3}, {7'd0, E_LU});
    go();
    ex_mem_read = 1'b0; #1;
    check("lu_clear", {7'd0, o3}, {7'd0, E_NORM});
    go();

    // Branch pulse, with load-use present to show branch priority
    branch_taken = 1'b1; ex_mem_read = 1'b1; #1;
    check("branch", {7'd0, o3}, {7'd0, E_BR});
    go();
    branch_taken = 1'b0; ex_mem_read = 1'b0; #1;
    check("branch_end", {7'd0, o3}, {7'd0, E_NORM});
    go();

    // Memory wait: mem_req held 3 cycles
    idle_inputs();
    mem_req = 1'b1; #1;
    check("mw3_c1", {7'd0, o3}, {7'd0, E_FRZ});
    check("mw2_c1", {7'd0, o2}, {7'd0, E_FRZ});
    check("mw1_nostall", {7'd0, o1}, {7'd0, E_NORM});
    go(); #1;
    check("mw3_c2", {7'd0, o3}, {7'd0, E_FRZ});
    check("mw2_release", {7'd0, o2}, {7'd0, E_NORM});
    check("mw4_c2", {7'd0, o4}, {7'd0, E_FRZ});
    go(); #1;
    check("mw3_release", {7'd0, o3}, {7'd0, E_NORM});
    check("mw2_afresh", {7'd0, o2}, {7'd0, E_FRZ});
    check("mw4_c3", {7'd0, o4}, {7'd0, E_FRZ});
    go();
    mem_req = 1'b0; #1;
    check("mw3_after", {7'd0, o3}, {7'd0, E_NORM});
    check("mw4_release", {7'd0, o4}, {7'd0, E_NORM});
    go();

    // Stall + branch together at MEM_LAT=2
    do_reset();
    mem_req = 1'b1; branch_taken = 1'b1; #1;
    check("sb_freeze", {7'd0, o2}, {7'd0, E_FRZ});
    go(); #1;
    check("sb_release_flush", {7'd0, o2}, {7'd0, E_BR});
    go();
    mem_req = 1'b0; branch_taken = 1'b0; #1;
    check("sb_after", {7'd0, o2}, {7'd0, E_NORM});
    go();

    // Reset on the 2nd freeze cycle at MEM_LAT=4
    do_reset();
    mem_req = 1'b1; #1;
    check("rmw_freeze1", {7'd0, o4}, {7'd0, E_FRZ});
    go();
    rst = 1'b1; #1;
    check("rmw_reset", {7'd0, o4}, {7'd0, E_RST});
    go();
    rst = 1'b0; mem_req = 1'b0; #1;
    check("rmw_run", {7'd0, o4}, {7'd0, E_NORM});
    go();

    // Halt: entry cycle, then sticky regardless of other requests
    halt_req = 1'b1; #1;
    check("halt_entry", {7'd0, o3}, {7'd0, E_HLTIN});
    go();
    halt_req = 1'b0; mem_req = 1'b1; branch_taken = 1'b1; #1;
    for (int i = 0; i < 3; i++) begin
      check("halted", {7'd0, o3}, {7'd0, E_HALT});
      go(); #1;
    end
`ifdef PIPE_STALL_PERF_EN
    for (int i = 0; i < 65540; i++) go();
    #1;
    check("stall_sat", sc3, 16'hFFFF);
    check("halted_long", {7'd0, o3}, {7'd0, E_HALT});
`endif
    rst = 1'b1; #1;
    check("halt_reset", {7'd0, o3}, {7'd0, E_RST});
    go();
    idle_inputs(); #1;
    check("halt_exit", {7'd0, o3}, {7'd0, E_NORM});
`ifdef PIPE_STALL_PERF_EN
    check("stall_clear", sc3, 16'h0000);
    check("flush_clear", fe3, 16'h0000);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
